// File: rtl/rps_pkg.sv
// Shared types and move-comparison helpers for the rock-paper-scissors arena.
package rps_pkg;

    typedef enum logic [2:0] {
        R = 3'b100,
        P = 3'b010,
        S = 3'b001
    } move_t;

    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
        DONE
    } state_t;

    function automatic logic is_valid(logic [2:0] m);
        return (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
    endfunction

    // Invalid moves beat nobody and lose to every valid move.
    function automatic logic beats(move_t a, move_t b);
        if (!is_valid(a)) return 1'b0;
        if (!is_valid(b)) return 1'b1;
        return (a == R && b == S) || (a == S && b == P) || (a == P && b == R);
    endfunction

endpackage

// File: rtl/rps_round_eval.sv
// Combinational pairwise evaluator: wins[i] counts opponents that player i beats.
module rps_round_eval
    import rps_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int W_W         = $clog2(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS-1:0][2:0]     moves,
    output logic [NUM_PLAYERS-1:0][W_W-1:0] wins
);

    always_comb begin
        wins = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j != i && beats(move_t'(moves[i]), move_t'(moves[j])))
                    wins[i] = wins[i] + W_W'(1);
            end
        end
    end

endmodule

// File: rtl/rps_arena.sv
// Multi-player rock-paper-scissors arena: move collection, round scoring,
// saturating score accumulation and optional fixed-length matches.
module rps_arena
    import rps_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 32,
    parameter int MATCH_ROUNDS = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3*NUM_PLAYERS-1:0]         move,
    input  logic [NUM_PLAYERS-1:0]           go,
    output logic                             busy,
    output logic [SCORE_W*NUM_PLAYERS-1:0]   score,
    output logic                             round_done,
    output logic [15:0]                      round_cnt,
    output logic                             match_done,
    output logic [$clog2(NUM_PLAYERS)-1:0]   winner,
    output logic                             tie
);

    localparam int W_W   = $clog2(NUM_PLAYERS);
    localparam int SUM_W = ((SCORE_W > W_W) ? SCORE_W : W_W) + 1;

    state_t                              state, state_nxt;
    logic [NUM_PLAYERS-1:0]              latched;
    logic [NUM_PLAYERS-1:0][2:0]         mv_in, mv_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_nxt;
    logic [NUM_PLAYERS-1:0][W_W-1:0]     wins;
    logic [SUM_W-1:0]                    sum;
    logic [15:0]                         cnt_nxt;
    logic [W_W-1:0]                      best_idx;
    logic [W_W:0]                        eq_cnt;
    logic                                tie_c;

    assign mv_in = move;
    assign score = score_q;

    rps_round_eval #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .W_W         (W_W)
    ) u_eval (
        .moves (mv_q),
        .wins  (wins)
    );

    // Widen before adding so a carry out of SCORE_W bits can be detected and clamped.
    always_comb begin
        sum       = '0;
        score_nxt = score_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            sum = SUM_W'(score_q[i]) + SUM_W'(wins[i]);
            score_nxt[i] = (sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        end
    end

    assign cnt_nxt = (round_cnt == 16'hFFFF) ? round_cnt : round_cnt + 16'd1;

    // Winner is judged on the post-update scores so it lines up with match_done.
    always_comb begin
        best_idx = '0;
        eq_cnt   = '0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (score_nxt[i] > score_nxt[best_idx])
                best_idx = W_W'(i);
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_nxt[i] == score_nxt[best_idx])
                eq_cnt = eq_cnt + (W_W+1)'(1);
        end
        tie_c = (eq_cnt > (W_W+1)'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (&(latched | go)) state_nxt = EVAL;
            EVAL:    state_nxt = (MATCH_ROUNDS != 0 && cnt_nxt == 16'(MATCH_ROUNDS)) ? DONE : COLLECT;
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched    <= '0;
            mv_q       <= '0;
            score_q    <= '0;
            round_cnt  <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            match_done <= 1'b0;
            winner     <= '0;
            tie        <= 1'b0;
        end else begin
            round_done <= 1'b0;
            match_done <= 1'b0;
            busy       <= (state_nxt != COLLECT);
            case (state)
                COLLECT: begin
                    // First move wins; repeated go from a latched player is ignored.
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (go[i] && !latched[i]) mv_q[i] <= mv_in[i];
                    end
                    latched <= latched | go;
                end
                EVAL: begin
                    score_q    <= score_nxt;
                    latched    <= '0;
                    round_cnt  <= cnt_nxt;
                    round_done <= 1'b1;
                    if (state_nxt == DONE) begin
                        match_done <= 1'b1;
                        winner     <= best_idx;
                        tie        <= tie_c;
                    end
                end
                DONE: begin
                    score_q   <= '0;
                    round_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_arena.sv
// Directed bench for rps_arena across several parameterisations.
module tb_rps_arena;

    localparam logic [2:0] RK = 3'b100;
    localparam logic [2:0] PA = 3'b010;
    localparam logic [2:0] SC = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N=2, SCORE_W=2, endless
    logic [5:0]  move2 = '0;
    logic [1:0]  go2 = '0;
    logic        busy2, rd2, md2, tie2;
    logic [3:0]  score2;
    logic [15:0] cnt2;
    logic [0:0]  win2;

    // N=3, SCORE_W=8, endless
    logic [8:0]  move3 = '0;
    logic [2:0]  go3 = '0;
    logic        busy3, rd3, md3, tie3;
    logic [23:0] score3;
    logic [15:0] cnt3;
    logic [1:0]  win3;

    // N=4, SCORE_W=8, endless
    logic [11:0] move4 = '0;
    logic [3:0]  go4 = '0;
    logic        busy4, rd4, md4, tie4;
    logic [31:0] score4;
    logic [15:0] cnt4;
    logic [1:0]  win4;

    // N=2, SCORE_W=8, 3-round matches
    logic [5:0]  movem = '0;
    logic [1:0]  gom = '0;
    logic        busym, rdm, mdm, tiem;
    logic [15:0] scorem;
    logic [15:0] cntm;
    logic [0:0]  winm;

    rps_arena #(.NUM_PLAYERS(2), .SCORE_W(2), .MATCH_ROUNDS(0)) u2 (
        .clk(clk), .rst(rst), .move(move2), .go(go2), .busy(busy2), .score(score2),
        .round_done(rd2), .round_cnt(cnt2), .match_done(md2), .winner(win2), .tie(tie2));
    rps_arena #(.NUM_PLAYERS(3), .SCORE_W(8), .MATCH_ROUNDS(0)) u3 (
        .clk(clk), .rst(rst), .move(move3), .go(go3), .busy(busy3), .score(score3),
        .round_done(rd3), .round_cnt(cnt3), .match_done(md3), .winner(win3), .tie(tie3));
    rps_arena #(.NUM_PLAYERS(4), .SCORE_W(8), .MATCH_ROUNDS(0)) u4 (
        .clk(clk), .rst(rst), .move(move4), .go(go4), .busy(busy4), .score(score4),
        .round_done(rd4), .round_cnt(cnt4), .match_done(md4), .winner(win4), .tie(tie4));
    rps_arena #(.NUM_PLAYERS(2), .SCORE_W(8), .MATCH_ROUNDS(3)) um (
        .clk(clk), .rst(rst), .move(movem), .go(gom), .busy(busym), .score(scorem),
        .round_done(rdm), .round_cnt(cntm), .match_done(mdm), .winner(winm), .tie(tiem));

    typedef struct {
        string       nm;
        logic [11:0] mv;   // {p3,p2,p1,p0}
        logic [31:0] dw;   // expected per-round gain {w3,w2,w1,w0}, 8 bits each
    } vec_t;

    vec_t vt[5];
    int   exp_s[4];
    logic [2:0] m0[6];
    logic [2:0] m1[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{"inv_mix",  {RK, SC, 3'b011, RK},     {8'd2, 8'd1, 8'd0, 8'd2}};
        vt[1] = '{"rpsr",     {RK, SC, PA, RK},         {8'd1, 8'd1, 8'd2, 8'd1}};
        vt[2] = '{"all_p",    {PA, PA, PA, PA},         {8'd0, 8'd0, 8'd0, 8'd0}};
        vt[3] = '{"two_inv",  {SC, RK, 3'b111, 3'b000}, {8'd2, 8'd3, 8'd0, 8'd0}};
        vt[4] = '{"sppr",     {RK, PA, PA, SC},         {8'd1, 8'd1, 8'd1, 8'd2}};
        m0 = '{RK, SC, RK, SC, SC, RK};
        m1 = '{SC, RK, RK, RK, RK, RK};
        for (int p = 0; p < 4; p++) exp_s[p] = 0;

        // Reset state
        step(); step();
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_score2", 32'(score2), 32'd0);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
        chk("rst_flags2", 32'({rd2, md2, win2, tie2}), 32'd0);
        chk("rst_flagsm", 32'({rdm, mdm, winm, tiem, busym}), 32'd0);
        rst = 1'b0;
        step();

        // N=2: R vs S, two-cycle latency, single-cycle busy
        move2 = {SC, RK}; go2 = 2'b11;
        step(); go2 = 2'b00;
        chk("t1_busy_eval", 32'(busy2), 32'd1);
        chk("t1_rd_early", 32'(rd2), 32'd0);
        step();
        chk("t1_rd", 32'(rd2), 32'd1);
        chk("t1_busy_low", 32'(busy2), 32'd0);
        chk("t1_s0", 32'(score2[1:0]), 32'd1);
        chk("t1_s1", 32'(score2[3:2]), 32'd0);
        chk("t1_cnt", 32'(cnt2), 32'd1);
        step();
        chk("t1_rd_pulse", 32'(rd2), 32'd0);

        // Saturation at 3 with a 2-bit score
        for (int r = 2; r <= 5; r++) begin
            go2 = 2'b11;
            step(); go2 = 2'b00;
            step();
            chk("sat_s0", 32'(score2[1:0]), (r > 3) ? 32'd3 : 32'(r));
        end
        chk("sat_s1", 32'(score2[3:2]), 32'd0);
        chk("sat_cnt", 32'(cnt2), 32'd5);

        // N=3 staggered, P0 re-goes with P which must be ignored
        move3 = {3'b000, 3'b000, RK}; go3 = 3'b001;
        step();
        move3 = {3'b000, PA, PA}; go3 = 3'b011;
        step();
        chk("t3_busy_wait", 32'(busy3), 32'd0);
        move3 = {SC, PA, PA}; go3 = 3'b101;
        step(); go3 = 3'b000;
        chk("t3_busy", 32'(busy3), 32'd1);
        step();
        chk("t3_rd", 32'(rd3), 32'd1);
        chk("t3_scores", 32'(score3), 32'h010101);

        // N=4 table
        for (int k = 0; k < 5; k++) begin
            move4 = vt[k].mv; go4 = 4'hF;
            step(); go4 = 4'h0;
            step();
            chk({vt[k].nm, "_rd"}, 32'(rd4), 32'd1);
            for (int p = 0; p < 4; p++) begin
                exp_s[p] += int'(vt[k].dw[p*8 +: 8]);
                chk({vt[k].nm, "_score"}, 32'(score4[p*8 +: 8]), 32'(exp_s[p]));
            end
        end

        // Two 3-round matches
        for (int r = 0; r < 6; r++) begin
            movem = {m1[r], m0[r]}; gom = 2'b11;
            step(); gom = 2'b00;
            chk("m_busy", 32'(busym), 32'd1);
            step();
            chk("m_rd", 32'(rdm), 32'd1);
            chk("m_cnt", 32'(cntm), 32'((r % 3) + 1));
            chk("m_md", 32'(mdm), (r % 3 == 2) ? 32'd1 : 32'd0);
            if (r == 2 || r == 5) begin
                chk("m_done_busy", 32'(busym), 32'd1);
                chk("m_scores", 32'(scorem), (r == 2) ? 32'h0101 : 32'h0200);
                chk("m_winner", 32'(winm), (r == 2) ? 32'd0 : 32'd1);
                chk("m_tie", 32'(tiem), (r == 2) ? 32'd1 : 32'd0);
                movem = {SC, RK}; gom = 2'b11;  // dropped: busy during DONE
                step(); gom = 2'b00;
                chk("m_clr_busy", 32'(busym), 32'd0);
                chk("m_clr_score", 32'(scorem), 32'd0);
                chk("m_clr_cnt", 32'(cntm), 32'd0);
                chk("m_md_pulse", 32'(mdm), 32'd0);
                step();
                chk("m_hold_win", 32'(winm), (r == 2) ? 32'd0 : 32'd1);
                chk("m_hold_tie", 32'(tiem), (r == 2) ? 32'd1 : 32'd0);
                chk("m_no_queue", 32'(busym), 32'd0);
            end
        end

        // Asynchronous reset during EVAL
        move2 = {SC, RK}; go2 = 2'b11;
        step(); go2 = 2'b00;
        chk("r_busy_eval", 32'(busy2), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("r_busy", 32'(busy2), 32'd0);
        chk("r_score", 32'(score2), 32'd0);
        chk("r_cnt", 32'(cnt2), 32'd0);
        chk("r_rd", 32'(rd2), 32'd0);
        chk("r_win_tiem", 32'({winm, tiem}), 32'd0);
        #1 rst = 1'b0;
        step(); step();
        chk("r_no_round", 32'({rd2, busy2}), 32'd0);
        chk("r_cnt_hold", 32'(cnt2), 32'd0);
        go2 = 2'b01;
        step(); go2 = 2'b00;
        step();
        chk("r_one_latched", 32'({rd2, busy2}), 32'd0);
        go2 = 2'b10;
        step();
        chk("r_busy2", 32'(busy2), 32'd1);
        go2 = 2'b11;  // presented while busy: must not carry over
        step(); go2 = 2'b00;
        chk("r_rd2", 32'(rd2), 32'd1);
        chk("r_s0", 32'(score2), 32'd1);
        step();
        chk("r_dropped", 32'(busy2), 32'd0);
        step();
        chk("r_cnt_final", 32'(cnt2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
